// File: rtl/mux_4x1_pkg.sv
// rtl/mux_4x1_pkg.sv - shared constants for the registered 4-to-1 selector
package mux_4x1_pkg;

   localparam int DEFAULT_WIDTH     = 4;
   localparam int DEFAULT_SEL_WIDTH = 2;
   localparam int NUM_INPUTS        = 4;

   // Number of select bits that actually address a source.
   localparam int SEL_LOW_BITS      = $clog2(NUM_INPUTS);

   localparam logic [1:0] SEL_IN0 = 2'd0;
   localparam logic [1:0] SEL_IN1 = 2'd1;
   localparam logic [1:0] SEL_IN2 = 2'd2;
   localparam logic [1:0] SEL_IN3 = 2'd3;

endpackage

// File: rtl/mux_4x1_core.sv
// rtl/mux_4x1_core.sv - combinational source select with select-range check
module mux_4x1_core
   import mux_4x1_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
   input  logic [WIDTH-1:0]     data_in_0,
   input  logic [WIDTH-1:0]     data_in_1,
   input  logic [WIDTH-1:0]     data_in_2,
   input  logic [WIDTH-1:0]     data_in_3,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic [WIDTH-1:0]     sel_data,
   output logic                 sel_bad
);

   // Any set bit above the two addressing bits means a code of 4 or more.
   generate
      if (SEL_WIDTH > SEL_LOW_BITS) begin : g_range_check
         assign sel_bad = |sel[SEL_WIDTH-1:SEL_LOW_BITS];
      end else begin : g_no_range_check
         assign sel_bad = 1'b0;
      end
   endgenerate

   // Only the addressed source reaches sel_data; out-of-range codes give zero.
   always_comb begin
      sel_data = '0;
      if (!sel_bad) begin
         case (sel[SEL_LOW_BITS-1:0])
            SEL_IN0: sel_data = data_in_0;
            SEL_IN1: sel_data = data_in_1;
            SEL_IN2: sel_data = data_in_2;
            SEL_IN3: sel_data = data_in_3;
            default: sel_data = '0;
         endcase
      end
   end

endmodule

// File: rtl/mux_4x1.sv
// rtl/mux_4x1.sv - registered 4-to-1 selector with valid and select-error flags
module mux_4x1
   import mux_4x1_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int SEL_WIDTH = DEFAULT_SEL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in_0,
   input  logic [WIDTH-1:0]     data_in_1,
   input  logic [WIDTH-1:0]     data_in_2,
   input  logic [WIDTH-1:0]     data_in_3,
   input  logic [SEL_WIDTH-1:0] sel,
   input  logic                 in_valid,
   output logic [WIDTH-1:0]     out,
   output logic                 out_valid,
   output logic                 sel_err
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_bad;

   mux_4x1_core #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_core (
      .data_in_0 (data_in_0),
      .data_in_1 (data_in_1),
      .data_in_2 (data_in_2),
      .data_in_3 (data_in_3),
      .sel       (sel),
      .sel_data  (sel_data),
      .sel_bad   (sel_bad)
   );

   // Capture the selected word on valid cycles; out holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end else if (in_valid) begin
         out       <= sel_data;
         out_valid <= 1'b1;
         sel_err   <= sel_bad;
      end else begin
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_4x1.sv
// tb/tb_mux_4x1.sv - scoreboard bench for the registered 4-to-1 selector
module tb_mux_4x1;

   localparam int W  = 4;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          clk_run = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  data_in_0 = '0;
   logic [W-1:0]  data_in_1 = '0;
   logic [W-1:0]  data_in_2 = '0;
   logic [W-1:0]  data_in_3 = '0;
   logic [SW-1:0] sel = '0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  out;
   logic          out_valid;
   logic          sel_err;

   mux_4x1 #(.WIDTH(W), .SEL_WIDTH(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in_0 (data_in_0),
      .data_in_1 (data_in_1),
      .data_in_2 (data_in_2),
      .data_in_3 (data_in_3),
      .sel       (sel),
      .in_valid  (in_valid),
      .out       (out),
      .out_valid (out_valid),
      .sel_err   (sel_err)
   );

   typedef struct {
      logic [W-1:0] d;
      logic         e;
      int           due;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] hold_val = '0;
   int           cyc = 0;
   int           tests = 0;
   int           fails = 0;

   initial begin
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a word addressed by sel 0..3 is that source, anything else is zero with error.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] d, input logic [SW-1:0] s, input logic v);
      logic [W-1:0] src[4];
      exp_t e;
      data_in_0 = a; data_in_1 = b; data_in_2 = c; data_in_3 = d;
      sel = s; in_valid = v;
      if (v) begin
         src[0] = a; src[1] = b; src[2] = c; src[3] = d;
         e.e   = (int'(s) >= 4);
         e.d   = e.e ? '0 : src[int'(s) % 4];
         e.due = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented word against the scoreboard; idle cycles must hold.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("latency", 32'(cyc), 32'(e.due));
               check("out", 32'(out), 32'(e.d));
               check("sel_err", 32'(sel_err), 32'(e.e));
               hold_val = e.d;
            end
         end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               check("missing_out_valid", 32'(out_valid), 32'd1);
               void'(sb.pop_front());
            end
            check("hold_out", 32'(out), 32'(hold_val));
            check("idle_sel_err", 32'(sel_err), 32'd0);
         end
      end
   end

   initial begin
      // Reset with no clock running.
      #1 rst = 1'b1;
      #1;
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sel_err", 32'(sel_err), 32'd0);
      clk_run = 1'b1;
      step(); step();
      rst = 1'b0;

      issue(4'b0001, 4'b0010, 4'b0100, 4'b1000, 3'd0, 1'b1);
      step();
      issue(4'b1111, 4'b0000, 4'b0000, 4'b1111, 3'd1, 1'b1);
      step();
      issue(4'b1010, 4'b0101, 4'b1010, 4'b0101, 3'd2, 1'b1);
      step();
      issue(4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'd3, 1'b1);
      step();
      issue(4'b1111, 4'b1111, 4'b1111, 4'b1111, 3'd0, 1'b0);
      step();
      step();
      issue(4'b1111, 4'b1111, 4'b1111, 4'b1111, 3'd4, 1'b1);
      step();
      issue(4'b0011, 4'b1100, 4'b0011, 4'b0011, 3'd1, 1'b1);
      step();
      issue(4'b1111, 4'b1111, 4'b1111, 4'b1111, 3'd7, 1'b1);
      step();
      issue(4'b0110, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b1);
      step();
      issue(4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);

      // Reset between edges while a word is presented.
      #2;
      check("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      sb.delete();
      hold_val = '0;
      #1;
      check("midrst_out", 32'(out), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sel_err", 32'(sel_err), 32'd0);
      data_in_2 = 4'b1001; sel = 3'd2; in_valid = 1'b1;
      step();
      check("held_rst_out", 32'(out), 32'd0);
      check("held_rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      check("post_rst_out", 32'(out), 32'd0);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      issue(4'b0000, 4'b0000, 4'b1001, 4'b0000, 3'd2, 1'b1);
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
         step();
      end
      issue(4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0);
      step(); step(); step();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
